seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 7-segment display encoder. Watches a time-multiplexed N-digit display drive (active-low segments in gfedcba order, active-low one-hot digit enables) and reconstructs the 4-bit hex value behind each digit.
- Sits on a capture or loopback path to check a display driver's output in-system. Publishes a complete multi-digit word once every digit has been seen stably.

Parameters:
- N_DIGITS, 4: number of multiplexed digits; value width is 4*N_DIGITS.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured. Legal range 1..255.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment drive {g,f,e,d,c,b,a}; 0 = segment lit.
- an_n  input  N_DIGITS  digit enables; 0 = digit active. Bit i = digit i.
- value  output  4*N_DIGITS  last complete word; digit i occupies value[4i+3:4i].
- value_valid  output  1  one-cycle pulse when value updates.
- digit_err  output  N_DIGITS  per-digit invalid-pattern flags for the published word; update together with value.
- frame_err  output  1  one-cycle pulse on a repeated digit before the frame completed.

Behaviour:
- Reset (async assert, sync-safe release): sample regs = all ones (blank); stability counter = 0; capture bitmap = 0; digit buffer = 0; value = 0; digit_err = 0; value_valid = 0; frame_err = 0.
- Stage 1: seg_n and an_n are registered every cycle into s_seg and s_an.
- Stable window: {an_n, seg_n} equals {s_an, s_seg} and s_an has exactly one zero bit.
  - While in the window, the counter increments, saturating at STABLE_CYCLES. Otherwise the counter clears to 0.
  - s_an all ones (blanking interval) or multi-hot never counts and never captures.
- Capture fires on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. It fires exactly once per dwell; an indefinitely held input does not recapture.
- Decode uses the 16 encoder patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern, including blank 1111111, is invalid: nibble 0, error bit set for that digit.
- On capture of digit i:
  - If bitmap[i] is already 1 (repeat before completion): frame_err pulses. The bitmap and the pending error bits are cleared, then digit i is recorded as the first digit of a new frame.
  - Otherwise, buffer[i] and the pending error bit i are written, and bitmap[i] is set.
- Frame completion: the capture that makes the bitmap all ones, on that same edge:
  - loads value from the buffer, including the nibble just captured;
  - loads digit_err from the pending error bits;
  - sets value_valid for one cycle and clears the bitmap.
- Latency: an input that changes before edge E0 and is held produces its capture at edge E_STABLE_CYCLES. If it completes the frame, value_valid is high during the cycle after that edge.
- Digit order within a frame is free; only set membership matters.
- Between completions, value and digit_err hold their last published contents.
- Asserting rst_n low mid-frame discards the partial frame immediately. Pulses drop the same instant.

Test Plan:
- Complete frame: N=4, S=4. Drive an_n=1110/seg 0011001, 1101/0110000, 1011/0100100, 0111/1111001, 8 cycles each -> single value_valid pulse; value=0x1234; digit_err=0000; pulse 5 cycles after the digit-3 pattern first appears.
- Glitch reject: hold each digit only 3 cycles (S=4), with a 1-cycle blank between digits -> no capture, no value_valid, value stays 0.
- Invalid pattern: as the complete-frame test but digit 2 driven 1111111 -> value=0x1034; digit_err=0100.
- Repeat digit: capture digits 0, 1, then digit 0 again (pattern 7), then digits 1, 2, 3 -> frame_err pulses once, on the second digit-0 capture; the next value_valid carries digit0=7.
- Non-one-hot enables: an_n=1100 or 1111 with a valid pattern held 20 cycles -> no capture, counter stays 0.
- Reset mid-frame: capture digits 0 and 1, pulse rst_n low 1 cycle, then drive digits 2 and 3 -> no value_valid until digits 0 and 1 are recaptured; outputs read 0 during and after reset.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Reconstructs hex digits from a time-multiplexed, active-low 7-segment drive.
// Publishes a full word once every digit has been captured from a stable dwell.
`timescale 1ns/1ps

module seg7_scan_decoder #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [N_DIGITS-1:0]     an_n,
    output logic [4*N_DIGITS-1:0]   value,
    output logic                    value_valid,
    output logic [N_DIGITS-1:0]     digit_err,
    output logic                    frame_err
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    // Returns {invalid, nibble}; anything off the encoder table decodes to 0 with invalid set.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b0000011: return 5'h0B;
            7'b1000110: return 5'h0C;
            7'b0100001: return 5'h0D;
            7'b0000110: return 5'h0E;
            7'b0001110: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    logic [6:0]                 s_seg;
    logic [N_DIGITS-1:0]        s_an;
    logic [7:0]                 stable_cnt;
    logic [7:0]                 cnt_next;
    logic [N_DIGITS-1:0]        bitmap;
    logic [N_DIGITS-1:0]        pend_err;
    logic [N_DIGITS-1:0][3:0]   buffer;

    logic                       in_window;
    logic                       capture;
    logic                       repeat_hit;
    logic                       complete;
    logic [4:0]                 dec;
    logic [N_DIGITS-1:0]        sel;
    logic [N_DIGITS-1:0]        bitmap_new;
    logic [N_DIGITS-1:0]        pend_new;
    logic [N_DIGITS-1:0][3:0]   buffer_new;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel        = ~s_an;
        in_window  = ({an_n, seg_n} == {s_an, s_seg}) && $onehot(sel);
        cnt_next   = 8'd0;
        if (in_window)
            cnt_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 8'd1;
        capture    = in_window && (stable_cnt == STABLE_MAX - 8'd1);

        dec        = decode(s_seg);
        repeat_hit = |(bitmap & sel);
        // A repeat restarts the frame with this digit as its first member.
        bitmap_new = (repeat_hit ? '0 : bitmap) | sel;
        pend_new   = repeat_hit ? '0 : pend_err;
        pend_new   = dec[4] ? (pend_new | sel) : (pend_new & ~sel);
        buffer_new = buffer;
        for (int i = 0; i < N_DIGITS; i++)
            if (sel[i])
                buffer_new[i] = dec[3:0];
        complete   = &bitmap_new;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the digit buffer is tiny and feeds the published word, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg       <= '1;
            s_an        <= '1;
            stable_cnt  <= 8'd0;
            bitmap      <= '0;
            pend_err    <= '0;
            buffer      <= '0;
            value       <= '0;
            digit_err   <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            s_seg       <= seg_n;
            s_an        <= an_n;
            stable_cnt  <= cnt_next;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (capture) begin
                buffer    <= buffer_new;
                pend_err  <= pend_new;
                frame_err <= repeat_hit;
                if (complete) begin
                    bitmap      <= '0;
                    value       <= buffer_new;
                    digit_err   <= pend_new;
                    value_valid <= 1'b1;
                end else begin
                    bitmap <= bitmap_new;
                end
            end
        end
    end

endmodule
